// File: rtl/sha256_nonce_search.sv
// Iterative double-SHA-256 nonce search engine; one round datapath runs UNROLL rounds per cycle.
// Define SHA_NONCE_SEARCH_HASH_OUT_EN to add found_hash (digest2 of the pending hit).
module sha256_nonce_search #(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned DIFFICULTY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_tail,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
  output logic [255:0] found_hash,
`endif
  output logic         done,
  output logic         busy,
  output logic [31:0]  nonces_tried
);

  typedef enum logic [2:0] {StIdle, StH1, StF1, StH2, StF2, StReport} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Word a in the low 32 bits, matching the midstate packing.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [5:0] LastRound = 6'(64 - UNROLL);

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [511:0] chunk1(input logic [95:0] tail, input logic [31:0] nonce);
    return {32'h00000280, 320'd0, 32'h80000000, nonce, tail};
  endfunction

  function automatic logic [511:0] chunk2(input logic [255:0] d1);
    return {32'h00000100, 192'd0, 32'h80000000, d1};
  endfunction

  state_e            state_q, state_d;
  logic [7:0][31:0]  work_q, work_d, rnd_work, mid_q, mid_d, digest;
  logic [15:0][31:0] w_q, w_d, rnd_w;
  logic [95:0]       tail_q, tail_d;
  logic [31:0]       end_q, end_d, nonce_q, nonce_d, tried_q, tried_d, found_q, found_d;
  logic [5:0]        round_q, round_d;
  logic              done_q, done_d;
  logic [31:0]       t1, t2;
  logic              hit, finish, advance;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
  logic [255:0]      hash_q, hash_d;
  assign found_hash = hash_q;
`endif

  assign work_ready   = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign found_valid  = (state_q == StReport);
  assign found_nonce  = found_q;
  assign done         = done_q;
  assign nonces_tried = tried_q;

  // UNROLL chained rounds; the schedule shifts in place so W[t] is always rnd_w[0].
  always_comb begin
    rnd_work = work_q;
    rnd_w    = w_q;
    t1       = '0;
    t2       = '0;
    for (int u = 0; u < int'(UNROLL); u++) begin
      t1 = rnd_work[7] + bsig1(rnd_work[4])
         + ((rnd_work[4] & rnd_work[5]) ^ (~rnd_work[4] & rnd_work[6]))
         + K[round_q + 6'(u)] + rnd_w[0];
      t2 = bsig0(rnd_work[0])
         + ((rnd_work[0] & rnd_work[1]) ^ (rnd_work[0] & rnd_work[2]) ^ (rnd_work[1] & rnd_work[2]));
      rnd_work = {rnd_work[6:4], rnd_work[3] + t1, rnd_work[2:0], t1 + t2};
      rnd_w    = {ssig1(rnd_w[14]) + rnd_w[9] + ssig0(rnd_w[1]) + rnd_w[0], rnd_w[15:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    w_d     = w_q;
    round_d = round_q;
    mid_d   = mid_q;
    tail_d  = tail_q;
    end_d   = end_q;
    nonce_d = nonce_q;
    tried_d = tried_q;
    found_d = found_q;
    done_d  = 1'b0;
    finish  = 1'b0;
    advance = 1'b0;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
    hash_d  = hash_q;
`endif
    // One feed-forward adder serves both F1 (midstate) and F2 (IV).
    for (int i = 0; i < 8; i++) begin
      digest[i] = ((state_q == StF1) ? mid_q[i] : IV[i]) + work_q[i];
    end
    hit = ((digest >> (256 - DIFFICULTY)) == '0);

    case (state_q)
      StIdle: begin
        if (work_valid) begin
          mid_d   = work_midstate;
          tail_d  = work_tail;
          end_d   = nonce_end;
          nonce_d = nonce_start;
          tried_d = '0;
          work_d  = work_midstate;
          w_d     = chunk1(work_tail, nonce_start);
          round_d = '0;
          state_d = StH1;
        end
      end
      StH1, StH2: begin
        work_d  = rnd_work;
        w_d     = rnd_w;
        round_d = round_q + 6'(UNROLL);
        if (round_q == LastRound) state_d = (state_q == StH1) ? StF1 : StF2;
      end
      StF1: begin
        work_d  = IV;
        w_d     = chunk2(digest);
        state_d = StH2;
      end
      StF2: begin
        tried_d = tried_q + 32'd1;
        if (hit) begin
          found_d = nonce_q;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
          hash_d  = digest;
`endif
          state_d = StReport;
        end else if (nonce_q == end_q) begin
          finish = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      StReport: begin
        if (found_ready) begin
          if (nonce_q == end_q) finish = 1'b1;
          else                  advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      nonce_d = nonce_q + 32'd1;
      work_d  = mid_q;
      w_d     = chunk1(tail_q, nonce_q + 32'd1);
      round_d = '0;
      state_d = StH1;
    end
    if (finish || (abort && state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      w_q     <= '0;
      round_q <= '0;
      mid_q   <= '0;
      tail_q  <= '0;
      end_q   <= '0;
      nonce_q <= '0;
      tried_q <= '0;
      found_q <= '0;
      done_q  <= 1'b0;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
      hash_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      w_q     <= w_d;
      round_q <= round_d;
      mid_q   <= mid_d;
      tail_q  <= tail_d;
      end_q   <= end_d;
      nonce_q <= nonce_d;
      tried_q <= tried_d;
      found_q <= found_d;
      done_q  <= done_d;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
      hash_q  <= hash_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_nonce_search.sv
// Bench for sha256_nonce_search: four instances (UNROLL/DIFFICULTY mixes) against a plain SHA-256 model.
module tb_sha256_nonce_search;

  localparam logic [255:0] MID =
    256'hbc909a33_6358bff0_90ccac7d_1e59caa8_c3c8d8e9_4f0103c8_96b18736_4719f91b;
  localparam logic [95:0]  TAIL = 96'h1d00ffff_4b1e5e4a_29ab5f49;
  localparam logic [255:0] IV   = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          g;
    logic [31:0] s;
    logic [31:0] e;
    int          n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ab, fr;
  logic [31:0] ns, ne;
  logic        wv [4];
  logic        wr [4], fv [4], dn [4], bz [4];
  logic [31:0] fn [4], nt [4];
  logic [31:0] hit_log [4][256];
  int          hit_cnt [4];
  int          checks = 0;
  int          errors = 0;
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
  logic [255:0] fh [4];
  logic [255:0] hash_log [4][256];
`endif

  always #5 clk = ~clk;

  // g0: U1/D1, g1: U1/D256, g2: U2/D1, g3: U4/D1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_nonce_search #(
      .UNROLL    ((g == 3) ? 4 : (g == 2) ? 2 : 1),
      .DIFFICULTY((g == 1) ? 256 : 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .work_valid   (wv[g]),
      .work_ready   (wr[g]),
      .work_midstate(MID),
      .work_tail    (TAIL),
      .nonce_start  (ns),
      .nonce_end    (ne),
      .abort        (ab),
      .found_valid  (fv[g]),
      .found_ready  (fr),
      .found_nonce  (fn[g]),
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
      .found_hash   (fh[g]),
`endif
      .done         (dn[g]),
      .busy         (bz[g]),
      .nonces_tried (nt[g])
    );
  end

  // Record every completed hit handshake (abort beats found_ready).
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (fv[g] && fr && !ab && hit_cnt[g] < 256) begin
        hit_log[g][hit_cnt[g]] <= fn[g];
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
        hash_log[g][hit_cnt[g]] <= fh[g];
`endif
        hit_cnt[g] <= hit_cnt[g] + 1;
      end
    end
  end

  function automatic int un_of(input int g);
    return (g == 3) ? 4 : (g == 2) ? 2 : 1;
  endfunction

  function automatic int df_of(input int g);
    return (g == 1) ? 256 : 1;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[32*i +: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = st[32*i +: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] model_d2(input logic [31:0] nonce);
    logic [255:0] d1;
    d1 = compress(MID, {32'h00000280, 320'd0, 32'h80000000, nonce, TAIL});
    return compress(IV, {32'h00000100, 192'd0, 32'h80000000, d1});
  endfunction

  function automatic bit model_hit(input logic [31:0] nonce, input int d);
    logic [255:0] h;
    h = model_d2(nonce);
    for (int b = 0; b < d; b++) if (h[255-b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one job with found_ready held high and check hits, count and done timing.
  task automatic run_job(input int g, input logic [31:0] s, input logic [31:0] e, input int n);
    logic [31:0] exp_h [64];
    logic [31:0] nn;
    int          nh, base, k, c2, got;
    nh = 0;
    for (int i = 0; i < n; i++) begin
      nn = s + 32'(i);
      if (model_hit(nn, df_of(g)) && nh < 64) begin
        exp_h[nh] = nn;
        nh++;
      end
    end
    base = hit_cnt[g];
    c2   = 2 * (64 / un_of(g)) + 2;
    fr = 1'b1; ns = s; ne = e; wv[g] = 1'b1;
    tick();
    wv[g] = 1'b0;
    check("busy after accept", 256'(bz[g]), 256'(1));
    k = 0;
    while (!dn[g] && k < n * c2 + n + 20) begin
      tick();
      k++;
    end
    check("done latency", 256'(k + 1), 256'(n * c2 + nh + 1));
    check("nonces_tried", 256'(nt[g]), 256'(n));
    check("ready with done", 256'(wr[g]), 256'(1));
    got = hit_cnt[g] - base;
    check("hit count", 256'(got), 256'(nh));
    for (int i = 0; i < nh && i < got; i++) begin
      check("hit nonce", 256'(hit_log[g][base+i]), 256'(exp_h[i]));
`ifdef SHA_NONCE_SEARCH_HASH_OUT_EN
      check("hit hash", hash_log[g][base+i], model_d2(exp_h[i]));
`endif
    end
  endtask

  initial begin
    vec_t        vecs [7];
    int          k;
    logic [31:0] first, t0;
    vecs[0] = '{1, 32'h00000010, 32'h00000013, 4};
    vecs[1] = '{1, 32'hFFFFFFFE, 32'h00000001, 4};
    vecs[2] = '{1, 32'h00000007, 32'h00000007, 1};
    vecs[3] = '{0, 32'h00000000, 32'h0000001F, 32};
    vecs[4] = '{2, 32'h00000000, 32'h0000001F, 32};
    vecs[5] = '{3, 32'h00000000, 32'h0000001F, 32};
    vecs[6] = '{3, 32'hFFFFFFFD, 32'h00000002, 6};
    rst_n = 1'b0; ab = 1'b0; fr = 1'b0; ns = '0; ne = '0;
    for (int g = 0; g < 4; g++) wv[g] = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < 4; g++) begin
      check("reset work_ready", 256'(wr[g]), 256'(1));
      check("reset found_valid", 256'(fv[g]), 256'(0));
      check("reset found_nonce", 256'(fn[g]), 256'(0));
      check("reset done", 256'(dn[g]), 256'(0));
      check("reset busy", 256'(bz[g]), 256'(0));
      check("reset nonces_tried", 256'(nt[g]), 256'(0));
    end
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) run_job(vecs[v].g, vecs[v].s, vecs[v].e, vecs[v].n);

    // Hold the first hit for 50 cycles, then abort together with found_ready.
    first = '0;
    for (int i = 31; i >= 0; i--) if (model_hit(32'(i), 1)) first = 32'(i);
    fr = 1'b0; ns = 32'h0; ne = 32'h1F; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    k = 0;
    while (!fv[0] && k < 5000) begin
      tick();
      k++;
    end
    check("hit pending", 256'(fv[0]), 256'(1));
    check("held nonce", 256'(fn[0]), 256'(first));
    t0 = nt[0];
    repeat (50) begin
      tick();
      check("nonce stable", 256'(fn[0]), 256'(first));
    end
    check("no progress", 256'(nt[0]), 256'(t0));
    check("valid held", 256'(fv[0]), 256'(1));
    ab = 1'b1; fr = 1'b1;
    tick();
    ab = 1'b0;
    check("report abort done", 256'(dn[0]), 256'(1));
    check("report abort valid", 256'(fv[0]), 256'(0));
    check("report abort ready", 256'(wr[0]), 256'(1));
    run_job(0, 32'h5, 32'h8, 4);

    // Abort ten cycles into H1, then re-accept.
    fr = 1'b1; ns = 32'h0; ne = 32'h1F; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    repeat (10) tick();
    ab = 1'b1;
    tick();
    ab = 1'b0;
    check("h1 abort done", 256'(dn[0]), 256'(1));
    check("h1 abort valid", 256'(fv[0]), 256'(0));
    check("h1 abort ready", 256'(wr[0]), 256'(1));
    check("h1 abort busy", 256'(bz[0]), 256'(0));
    run_job(0, 32'hFFFFFFFF, 32'h1, 3);

    // Asynchronous reset mid-H2.
    ns = 32'h0; ne = 32'h1F; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    repeat (70) tick();
    check("busy in h2", 256'(bz[0]), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid reset ready", 256'(wr[0]), 256'(1));
    check("mid reset busy", 256'(bz[0]), 256'(0));
    check("mid reset valid", 256'(fv[0]), 256'(0));
    check("mid reset done", 256'(dn[0]), 256'(0));
    check("mid reset tried", 256'(nt[0]), 256'(0));
    check("mid reset nonce", 256'(fn[0]), 256'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_job(0, 32'd100, 32'd103, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_search.md
# sha256_nonce_search

Iterative double-SHA-256 nonce search engine. It is the area-lean successor of the unrolled miner pipeline: one shared round datapath processes UNROLL rounds per cycle. The engine accepts a job (midstate, block tail, inclusive nonce range) over a valid/ready handshake and sweeps the range. It reports every nonce whose second digest meets the difficulty over a result handshake, then signals completion.

## Interface
- UNROLL, 1, rounds per cycle; legal 1, 2, 4; cycles per hash C = 64/UNROLL
- DIFFICULTY, 4, number of digest bits [255:256-DIFFICULTY] that must be zero; legal 1..256
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- work_valid  in  1  job offered
- work_ready  out  1  engine idle, job accepted when valid&ready
- work_midstate  in  256  state after chunk 1, word a at [31:0], word h at [255:224]
- work_tail  in  96  chunk-2 words W0..W2, W0 at [31:0]
- nonce_start  in  32  first nonce, inclusive
- nonce_end  in  32  last nonce, inclusive
- abort  in  1  synchronous job cancel
- found_valid  out  1  hit pending
- found_ready  in  1  consumer takes hit
- found_nonce  out  32  nonce of pending hit
- done  out  1  one-cycle pulse: range exhausted or aborted
- busy  out  1  job in progress (not IDLE)
- nonces_tried  out  32  completed nonces in the current job, wraps modulo 2^32

## Operation
- States: IDLE, H1, F1, H2, F2, REPORT.
- IDLE: work_ready=1. On accept, latch midstate/tail/end, nonce<=nonce_start, nonces_tried<=0, go H1.
- H1, C cycles: chunk 2 from midstate. W0..W2 = tail, W3 = nonce, W4 = 0x80000000, W5..W14 = 0, W15 = 0x00000280. Message schedule is an in-place 16-word shift register. The round constant is indexed by the round counter.
- F1, 1 cycle: digest1 = midstate + working vars, per 32-bit word mod 2^32. Load H2 with the standard IV 0x6a09e667..0x5be0cd19, packed word a at [31:0]. Chunk = digest1 in W0..W7, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100.
- H2, C cycles: same datapath.
- F2, 1 cycle: digest2 = IV + working vars. nonces_tried++.
  - Hit when digest2[255:256-DIFFICULTY]==0: found_nonce<=nonce, go REPORT.
  - Otherwise, if nonce==nonce_end: pulse done, go IDLE.
  - Otherwise nonce+1, go H1.
- REPORT: found_valid=1 held with found_nonce stable until found_ready. On handshake cycle: if nonce==nonce_end, pulse done and go IDLE; else nonce+1 and go H1.
- Range wraps: nonce_end < nonce_start sweeps through 0xFFFFFFFF to 0x00000000. nonce_start==nonce_end tests exactly one nonce.
- abort in any non-IDLE state: next state IDLE, done pulses, found_valid drops, pending hit discarded. abort in IDLE is ignored.
- A job offered while busy is held off (work_ready=0). No queuing.

## Timing
- Reset values: state IDLE, work_ready=1, found_valid=0, found_nonce=0, done=0, busy=0, nonces_tried=0, all datapath registers 0.
- Reset asserted mid-job discards the job immediately. No done pulse is issued.
- Per nonce without hit: 2C+2 cycles (130 at UNROLL=1, 66 at 2, 34 at 4).
- Accept at edge t: first H1 round at t+1. F2 of first nonce is in cycle t+2C+2. found_valid rises at t+2C+3 if hit.
- done pulses in the cycle after the F2 or REPORT-handshake cycle that finishes the last nonce.
- found_ready while found_valid=0 is ignored. found_valid never deasserts without a handshake, except on abort or reset.
- abort coincident with found_ready in REPORT: abort wins, hit counts as discarded.
- work_ready rises in the same cycle as done. A new job may be accepted that cycle.

## Configuration
- SHA_NONCE_SEARCH_HASH_OUT_EN defined: adds output found_hash [255:0], digest2 of the pending hit, valid with found_valid, reset 0.
- Undefined: port absent, digest2 not retained beyond F2. Search behaviour and timing are identical.

## Test plan
- Reset with found_ready=0, then release -> work_ready=1, all other outputs 0. Assert rst_n low for 1 cycle mid-H2 -> same values immediately.
- DIFFICULTY=256, UNROLL=1, range 0x10..0x13 -> no found_valid. done exactly 4×130+1 cycles after accept, nonces_tried=4.
- DIFFICULTY=1, range 0..31, found_ready tied 1 -> found_nonce sequence and (with macro) found_hash match the C reference model bit-exactly. Hold found_ready=0 for 50 cycles on first hit -> found_nonce stable, no progress.
- Wrap range start 0xFFFFFFFE, end 0x00000001, DIFFICULTY=256 -> nonces tested FFFFFFFE, FFFFFFFF, 0, 1. done after 4 nonces.
- abort 10 cycles into H1, and again during REPORT -> done one cycle later, found_valid 0, work_ready 1. Immediately re-accept a job -> results are correct.
- Sweep UNROLL=2 and UNROLL=4 on the DIFFICULTY=1 job -> identical hits to UNROLL=1. Per-nonce cycle counts 66 and 34.
